// File: rtl/fifo_pack_pkg.sv
// Shared types and helpers for the FIFO read-side word packer.
// The word width comes from the DATA define; it falls back to 8 when no defines file is supplied.
`ifndef DATA
`define DATA 8
`endif

package fifo_pack_pkg;

    localparam int PACK_DEFAULT = 4;
    localparam int CNT_W        = $clog2(PACK_DEFAULT);

    typedef logic [`DATA-1:0]        word_t;
    typedef logic [PACK_DEFAULT-1:0] keep_t;

    // Mask with the low n bits set, i.e. the keep pattern of a beat holding n words.
    function automatic logic [31:0] keep_mask(input logic [31:0] n);
        return (32'd1 << n) - 32'd1;
    endfunction

endpackage

// File: rtl/fifo_pack_timer.sv
// Idle timer that requests a flush of a partially filled beat.
// Only built with PACK_TIMEOUT_EN defined.
`ifdef PACK_TIMEOUT_EN
module fifo_pack_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic rclk,
    input  logic rrst,
    input  logic rinc,
    input  logic cnt_zero,
    input  logic flush,
    output logic fire
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    logic [TW-1:0] tmr_reg;

    always_ff @(posedge rclk) begin
        if (rrst || rinc || cnt_zero || flush) begin
            tmr_reg <= '0;
        end else if (tmr_reg != TMAX) begin
            tmr_reg <= tmr_reg + 1'b1;
        end
    end

    assign fire = (tmr_reg == TMAX);

endmodule
`endif

// File: rtl/fifo_rd_packer.sv
// Drains the async FIFO read port and packs PACK words into one valid/ready beat.
// Define PACK_TIMEOUT_EN to flush partial beats after TIMEOUT idle cycles.
`ifndef DATA
`define DATA 8
`endif

module fifo_rd_packer
    import fifo_pack_pkg::*;
#(
    parameter int DATA    = `DATA,
    parameter int PACK    = PACK_DEFAULT
`ifdef PACK_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 16
`endif
) (
    input  logic                 rclk,
    input  logic                 rrst,
    input  logic                 en,
    input  logic                 rempty,
    input  logic [DATA-1:0]      rdata,
    output logic                 rinc,
    output logic [DATA*PACK-1:0] out_data,
    output logic [PACK-1:0]      out_keep,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int CW = (PACK == PACK_DEFAULT) ? CNT_W : $clog2(PACK);
    localparam logic [CW-1:0] LAST = CW'(PACK - 1);

    logic [CW-1:0]            cnt_reg;
    logic [DATA-1:0]          slot_reg [PACK-1];
    logic [DATA*(PACK-1)-1:0] slot_flat;
    logic [DATA*PACK-1:0]     out_data_reg;
    logic [PACK-1:0]          out_keep_reg;
    logic                     out_valid_reg;

    logic last_word;
    logic stall;
    logic load;
    logic xfer;
    logic flush;

    assign last_word = (cnt_reg == LAST);
    // Only the word completing a beat must wait for the output register.
    assign stall     = last_word && out_valid_reg && !out_ready;
    assign rinc      = en && !rempty && !rrst && !stall;
    assign load      = rinc && last_word;
    assign xfer      = out_valid_reg && out_ready;

`ifdef PACK_TIMEOUT_EN
    logic tmr_fire;

    fifo_pack_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .rclk     (rclk),
        .rrst     (rrst),
        .rinc     (rinc),
        .cnt_zero (cnt_reg == '0),
        .flush    (flush),
        .fire     (tmr_fire)
    );

    // A read in the same cycle wins: the word is appended instead of flushing.
    assign flush = !rinc && tmr_fire && (cnt_reg != '0) && (!out_valid_reg || out_ready);
`else
    assign flush = 1'b0;
`endif

    // The final word of a beat bypasses the slots and goes straight to the output register.
    generate
        for (genvar gi = 0; gi < PACK - 1; gi++) begin : g_slot
            always_ff @(posedge rclk) begin
                if (rrst || load || flush) begin
                    slot_reg[gi] <= '0;
                end else if (rinc && (cnt_reg == CW'(gi))) begin
                    slot_reg[gi] <= rdata;
                end
            end
            assign slot_flat[gi*DATA +: DATA] = slot_reg[gi];
        end
    endgenerate

    always_ff @(posedge rclk) begin
        if (rrst || load || flush) begin
            cnt_reg <= '0;
        end else if (rinc) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            out_data_reg  <= '0;
            out_keep_reg  <= '0;
            out_valid_reg <= 1'b0;
        end else if (load) begin
            out_data_reg  <= {rdata, slot_flat};
            out_keep_reg  <= '1;
            out_valid_reg <= 1'b1;
        end else if (flush) begin
            out_data_reg  <= {{DATA{1'b0}}, slot_flat};
            out_keep_reg  <= PACK'(keep_mask(32'(cnt_reg)));
            out_valid_reg <= 1'b1;
        end else if (xfer) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_data  = out_data_reg;
    assign out_keep  = out_keep_reg;
    assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Scoreboard bench for fifo_rd_packer: a queue models the FIFO, expected beats are queued as words are pushed.
// Timeout scenarios run only when PACK_TIMEOUT_EN is defined.
module tb_fifo_rd_packer;

    localparam int DATA = 8;
    localparam int PACK = 4;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
    } beat_t;

    logic        rclk = 1'b0;
    logic        rrst;
    logic        en;
    logic        rempty;
    logic [7:0]  rdata;
    logic        rinc;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_valid;
    logic        out_ready;

    logic [7:0]  fq[$];
    logic [7:0]  acc[$];
    beat_t       expq[$];
    logic        take;
    int          total = 0;
    int          bad = 0;
    int          xfer_cnt = 0;

    always #5 rclk = ~rclk;

    fifo_rd_packer #(
        .DATA (DATA),
        .PACK (PACK)
`ifdef PACK_TIMEOUT_EN
        ,
        .TIMEOUT (16)
`endif
    ) dut (
        .rclk      (rclk),
        .rrst      (rrst),
        .en        (en),
        .rempty    (rempty),
        .rdata     (rdata),
        .rinc      (rinc),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic update_fifo();
        rempty = (fq.size() == 0);
        rdata  = (fq.size() != 0) ? fq[0] : 8'h00;
    endtask

    task automatic push_word(input logic [7:0] w);
        beat_t b;
        fq.push_back(w);
        acc.push_back(w);
        if (acc.size() == PACK) begin
            b.data = {acc[3], acc[2], acc[1], acc[0]};
            b.keep = 4'hF;
            expq.push_back(b);
            acc.delete();
        end
        update_fifo();
    endtask

    // Words pushed this way are expected to be discarded by a reset.
    task automatic push_lost(input logic [7:0] w);
        fq.push_back(w);
        update_fifo();
    endtask

    task automatic push_partial_expect();
        beat_t b;
        logic [31:0] d;
        d = '0;
        for (int i = 0; i < acc.size(); i++) d[i*8 +: 8] = acc[i];
        b.data = d;
        b.keep = 4'((1 << acc.size()) - 1);
        expq.push_back(b);
        acc.delete();
    endtask

    // One clock: sample the read strobe mid-cycle, then pop the model FIFO just after the edge.
    task automatic tick();
        @(negedge rclk);
        take = rinc;
        @(posedge rclk);
        #1;
        if (take) void'(fq.pop_front());
        update_fifo();
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((fq.size() != 0 || expq.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 64'(n < budget), 64'd1);
    endtask

    always @(negedge rclk) begin
        if (!rrst && out_valid) begin
            if (expq.size() == 0) begin
                chk("beat_unexpected", 64'd1, 64'd0);
            end else begin
                chk("beat_data", 64'(out_data), 64'(expq[0].data));
                chk("beat_keep", 64'(out_keep), 64'(expq[0].keep));
                if (out_ready) begin
                    $display("beat %08h keep %h", out_data, out_keep);
                    void'(expq.pop_front());
                    xfer_cnt++;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int run;
        int x0;
        logic [31:0] held;

        rrst = 1'b1;
        en = 1'b1;
        out_ready = 1'b1;
        take = 1'b0;
        update_fifo();

        // Reset with data available: no reads may happen
        push_word(8'h11); push_word(8'h22); push_word(8'h33); push_word(8'h44);
        tick(); chk("rst_rinc0", 64'(take), 64'd0);
        tick(); chk("rst_rinc1", 64'(take), 64'd0);
        rrst = 1'b0;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_keep", 64'(out_keep), 64'd0);

        // Basic pack 0x44332211, one-cycle valid
        drain("basic_drain", 20);
        chk("basic_valid_drop", 64'(out_valid), 64'd0);

        // Throughput: 12 words, 12 back-to-back reads, 3 beats
        x0 = xfer_cnt;
        for (int i = 0; i < 12; i++) push_word(8'(8'h50 + i));
        run = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            run += int'(take);
        end
        chk("tput_rinc", 64'(run), 64'd12);
        drain("tput_drain", 20);
        chk("tput_beats", 64'(xfer_cnt - x0), 64'd3);

        // Backpressure: 7 reads then stall with beat held
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) push_word(8'(8'hA0 + i));
        run = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            run += int'(take);
        end
        chk("bp_reads", 64'(run), 64'd7);
        chk("bp_stall", 64'(take), 64'd0);
        chk("bp_fifo_left", 64'(fq.size()), 64'd1);
        held = out_data;
        tick(); tick();
        chk("bp_held", 64'(out_data), 64'(held));
        chk("bp_held_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        drain("bp_drain", 20);

        // Reset mid-beat discards two partial words
        push_lost(8'h01); push_lost(8'h02);
        tick(); tick(); tick();
        rrst = 1'b1;
        tick();
        rrst = 1'b0;
        chk("midrst_valid", 64'(out_valid), 64'd0);
        push_word(8'hAA); push_word(8'hBB); push_word(8'hCC); push_word(8'hDD);
        drain("midrst_drain", 20);

        // en=0 mid-beat holds state; draining resumes
        push_word(8'h61); push_word(8'h62);
        tick(); tick();
        en = 1'b0;
        push_word(8'h63); push_word(8'h64);
        run = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            run += int'(take);
        end
        chk("en0_noread", 64'(run), 64'd0);
        chk("en0_novalid", 64'(out_valid), 64'd0);
        en = 1'b1;
        drain("en_drain", 20);

`ifdef PACK_TIMEOUT_EN
        // Partial flush after 16 idle cycles
        push_word(8'h01); push_word(8'h02);
        push_partial_expect();
        tick(); tick();
        for (int i = 0; i < 15; i++) tick();
        chk("to_not_yet", 64'(out_valid), 64'd0);
        tick();
        chk("to_flush_valid", 64'(out_valid), 64'd1);
        chk("to_flush_keep", 64'(out_keep), 64'h3);
        chk("to_flush_data", 64'(out_data), 64'h0000_0201);
        drain("to_drain", 20);

        // Word arriving on the flush cycle is appended instead
        push_word(8'h03); push_word(8'h04);
        tick(); tick();
        for (int i = 0; i < 15; i++) tick();
        push_word(8'h05);
        tick();
        chk("to_append_read", 64'(take), 64'd1);
        chk("to_append_noflush", 64'(out_valid), 64'd0);
        push_word(8'h06);
        drain("to_append_drain", 20);
`else
        // Without the timer a partial beat is never emitted
        push_word(8'h71); push_word(8'h72);
        tick(); tick(); tick();
        for (int i = 0; i < 20; i++) tick();
        chk("idle_no_partial", 64'(out_valid), 64'd0);
        push_word(8'h73); push_word(8'h74);
        drain("idle_drain", 20);
`endif

        chk("all_beats_seen", 64'(expq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
